// File: rtl/cbd_sampler.sv
// cbd_sampler: centered binomial sampler (eta=2) for the Kyber768 encapsulation path.
// Takes the 1024-bit SHAKE256 PRF string once the XOF reports done. It then streams
// N coefficients, reduced mod Q, over a valid/ready interface.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   start        request one polynomial (pulse or level); ignored while busy
//   prf_in       PRF output string, bit i of the stream = prf_in[i]
//   prf_valid    PRF done flag; prf_in stable while high
//   coeff_out    current coefficient in [0, Q-1]
//   coeff_idx    index of coeff_out
//   coeff_valid  coeff_out/coeff_idx valid
//   coeff_ready  downstream accepts when high together with coeff_valid
//   busy         high while waiting for the PRF or emitting
//   done         high once the whole polynomial has been transferred
module cbd_sampler #(
  parameter int Q    = 3329,
  parameter int N    = 256,
  parameter int IN_W = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] prf_in,
  input  logic            prf_valid,
  output logic [11:0]     coeff_out,
  output logic [7:0]      coeff_idx,
  output logic            coeff_valid,
  input  logic            coeff_ready,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(N - 1);
  localparam logic [11:0] Q12      = 12'(Q);

  state_t          state;
  logic [IN_W-1:0] pbuf;

  // a = b0+b1, b = b2+b3. A negative difference maps to Q-|d| with a single subtract.
  function automatic logic [11:0] cbd_map(input logic [3:0] nib);
    logic [1:0] a;
    logic [1:0] b;
    a = {1'b0, nib[0]} + {1'b0, nib[1]};
    b = {1'b0, nib[2]} + {1'b0, nib[3]};
    if (a >= b) cbd_map = {10'd0, a - b};
    else        cbd_map = Q12 - {10'd0, b - a};
  endfunction

  // The buffer shifts down one nibble per transfer, so the next coefficient is always
  // taken from pbuf[7:4]. This replaces a 256-way mux with a fixed tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pbuf        <= '0;
      coeff_out   <= '0;
      coeff_idx   <= '0;
      coeff_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ARM: begin
          if (state == ARM || start) begin
            busy <= 1'b1;
            done <= 1'b0;
            if (prf_valid) begin
              pbuf        <= prf_in;
              coeff_out   <= cbd_map(prf_in[3:0]);
              coeff_idx   <= '0;
              coeff_valid <= 1'b1;
              state       <= EMIT;
            end else begin
              state <= ARM;
            end
          end
        end
        EMIT: begin
          if (coeff_ready) begin
            if (coeff_idx == LAST_IDX) begin
              coeff_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              coeff_idx <= coeff_idx + 8'd1;
              coeff_out <= cbd_map(pbuf[7:4]);
              pbuf      <= pbuf >> 4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbd_sampler.sv
// Directed self-checking bench for cbd_sampler.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cbd_sampler;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1023:0] prf_in;
  logic          prf_valid;
  logic [11:0]   coeff_out;
  logic [7:0]    coeff_idx;
  logic          coeff_valid;
  logic          coeff_ready;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  cbd_sampler #(.Q(3329), .N(256), .IN_W(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prf_in      (prf_in),
    .prf_valid   (prf_valid),
    .coeff_out   (coeff_out),
    .coeff_idx   (coeff_idx),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference CBD taken directly from the bit definition.
  function automatic logic [11:0] cbd_ref(input logic [1023:0] v, input int k);
    int d;
    d = int'(v[4*k]) + int'(v[4*k+1]) - int'(v[4*k+2]) - int'(v[4*k+3]);
    return (d < 0) ? 12'(3329 + d) : 12'(d);
  endfunction

  // Expected values for the directed vectors, worked out by hand.
  function automatic logic [11:0] hand_exp(input int sel, input int k);
    if (sel == 0) begin
      case (k)
        0: return 12'd1;     // nibble 0x1
        1: return 12'd2;     // nibble 0x3
        3: return 12'd3327;  // nibble 0xC -> -2
        default: return 12'd0;
      endcase
    end else if (sel == 2 && k == 0) begin
      return 12'd3328;       // nibble 0x4 -> -1
    end
    return 12'd0;
  endfunction

  task automatic rand_vec(output logic [1023:0] v);
    for (int unsigned i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; prf_valid = 1'b0; coeff_ready = 1'b0; prf_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({coeff_out, coeff_idx, coeff_valid, busy, done} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got out=%0d idx=%0d v=%0b busy=%0b done=%0b exp all 0",
               coeff_out, coeff_idx, coeff_valid, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({coeff_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got v=%0b busy=%0b done=%0b exp 000", coeff_valid, busy, done);
    end
  endtask

  task automatic test_zeros;
    prf_in = '0; prf_valid = 1'b1; start = 1'b1; coeff_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; prf_valid = 1'b0;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if ({coeff_valid, coeff_idx, coeff_out, busy} !== {1'b1, 8'(k), 12'd0, 1'b1}) begin
        failures++;
        $display("FAIL zeros_stream k=%0d got v=%0b idx=%0d out=%0d busy=%0b exp v=1 idx=%0d out=0 busy=1",
                 k, coeff_valid, coeff_idx, coeff_out, busy, k);
      end
      @(negedge clk);
    end
    checks++;
    if ({coeff_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL zeros_done got v=%0b busy=%0b done=%0b exp 001", coeff_valid, busy, done);
    end
  endtask

  // Each run starts from DONE, which also checks that start in DONE captures directly.
  task automatic test_patterns;
    logic [1023:0] vecs [3];
    vecs[0] = 1024'hC031;
    vecs[1] = '1;
    vecs[2] = '1;
    vecs[2][3:0] = 4'h4;
    for (int s = 0; s < 3; s++) begin
      prf_in = vecs[s]; prf_valid = 1'b1; start = 1'b1; coeff_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; prf_valid = 1'b0; prf_in = ~vecs[s];
      checks++;
      if ({done, busy} !== 2'b01) begin
        failures++;
        $display("FAIL pattern_restart sel=%0d got done=%0b busy=%0b exp done=0 busy=1", s, done, busy);
      end
      for (int k = 0; k < 256; k++) begin
        checks++;
        if ({coeff_valid, coeff_idx, coeff_out} !== {1'b1, 8'(k), hand_exp(s, k)}) begin
          failures++;
          $display("FAIL pattern sel=%0d k=%0d got v=%0b idx=%0d out=%0d exp v=1 idx=%0d out=%0d",
                   s, k, coeff_valid, coeff_idx, coeff_out, k, hand_exp(s, k));
        end
        @(negedge clk);
      end
      checks++;
      if ({coeff_valid, done} !== 2'b01) begin
        failures++;
        $display("FAIL pattern_done sel=%0d got v=%0b done=%0b exp v=0 done=1", s, coeff_valid, done);
      end
    end
  endtask

  task automatic test_arm;
    logic [1023:0] v;
    rand_vec(v);
    prf_in = v; prf_valid = 1'b0; start = 1'b1; coeff_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({busy, coeff_valid, done} !== 3'b100) begin
        failures++;
        $display("FAIL arm_wait c=%0d got busy=%0b v=%0b done=%0b exp 100", c, busy, coeff_valid, done);
      end
      if (c == 2) start = 1'b1;      // start in ARM is ignored
      if (c == 3) start = 1'b0;
      if (c == 4) prf_valid = 1'b1;  // five cycles after start
      else @(negedge clk);
    end
    @(negedge clk);
    prf_valid = 1'b0; prf_in = '0;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if ({coeff_valid, coeff_idx, coeff_out} !== {1'b1, 8'(k), cbd_ref(v, k)}) begin
        failures++;
        $display("FAIL arm_stream k=%0d got v=%0b idx=%0d out=%0d exp v=1 idx=%0d out=%0d",
                 k, coeff_valid, coeff_idx, coeff_out, k, cbd_ref(v, k));
      end
      @(negedge clk);
    end
    checks++;
    if ({coeff_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL arm_done got v=%0b busy=%0b done=%0b exp 001", coeff_valid, busy, done);
    end
  endtask

  task automatic test_stall;
    logic [1023:0] v;
    int            n = 0;
    bit            pulsed = 1'b0;
    bit            stalled = 1'b0;
    logic [19:0]   held = '0;
    rand_vec(v);
    prf_in = v; prf_valid = 1'b1; start = 1'b1; coeff_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; prf_valid = 1'b0;
    for (int c = 0; c < 2000 && n < 256; c++) begin
      if (start) begin start = 1'b0; prf_valid = 1'b0; end
      checks++;
      if ({coeff_valid, coeff_idx, coeff_out} !== {1'b1, 8'(n), cbd_ref(v, n)}) begin
        failures++;
        $display("FAIL stall_stream n=%0d got v=%0b idx=%0d out=%0d exp v=1 idx=%0d out=%0d",
                 n, coeff_valid, coeff_idx, coeff_out, n, cbd_ref(v, n));
      end
      if (stalled) begin
        checks++;
        if ({coeff_idx, coeff_out} !== held) begin
          failures++;
          $display("FAIL stall_hold got idx=%0d out=%0d exp idx=%0d out=%0d",
                   coeff_idx, coeff_out, held[19:12], held[11:0]);
        end
      end
      held = {coeff_idx, coeff_out};
      if (n == 50 && !pulsed) begin
        pulsed = 1'b1; start = 1'b1; prf_valid = 1'b1; prf_in = ~v;
      end
      coeff_ready = 1'($urandom_range(0, 1));
      stalled = !coeff_ready;
      if (coeff_ready) n++;
      @(negedge clk);
    end
    start = 1'b0; prf_valid = 1'b0;
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL stall_count got %0d transfers exp 256", n);
    end
    checks++;
    if ({coeff_valid, done} !== 2'b01) begin
      failures++;
      $display("FAIL stall_done got v=%0b done=%0b exp v=0 done=1", coeff_valid, done);
    end
  endtask

  task automatic test_rst_mid;
    logic [1023:0] v;
    rand_vec(v);
    prf_in = v; prf_valid = 1'b1; start = 1'b1; coeff_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; prf_valid = 1'b0;
    for (int k = 0; k < 100; k++) @(negedge clk);
    checks++;
    if ({coeff_valid, coeff_idx} !== {1'b1, 8'd100}) begin
      failures++;
      $display("FAIL rst_mid_pos got v=%0b idx=%0d exp v=1 idx=100", coeff_valid, coeff_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({coeff_out, coeff_idx, coeff_valid, busy, done} !== 23'd0) begin
      failures++;
      $display("FAIL rst_mid_async got out=%0d idx=%0d v=%0b busy=%0b done=%0b exp all 0",
               coeff_out, coeff_idx, coeff_valid, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({coeff_out, coeff_idx, coeff_valid, busy, done} !== 23'd0) begin
      failures++;
      $display("FAIL rst_mid_idle got out=%0d idx=%0d v=%0b busy=%0b done=%0b exp all 0",
               coeff_out, coeff_idx, coeff_valid, busy, done);
    end
    prf_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; prf_valid = 1'b0;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if ({coeff_valid, coeff_idx, coeff_out} !== {1'b1, 8'(k), cbd_ref(v, k)}) begin
        failures++;
        $display("FAIL rst_fresh k=%0d got v=%0b idx=%0d out=%0d exp v=1 idx=%0d out=%0d",
                 k, coeff_valid, coeff_idx, coeff_out, k, cbd_ref(v, k));
      end
      @(negedge clk);
    end
    checks++;
    if ({coeff_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL rst_fresh_done got v=%0b busy=%0b done=%0b exp 001", coeff_valid, busy, done);
    end
  endtask

  initial begin
    test_reset;
    test_zeros;
    test_patterns;
    test_arm;
    test_stall;
    test_rst_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cbd_sampler.md
Name: cbd_sampler

Overview:
- Consumer of the SHAKE256 PRF output in the Kyber768 encapsulation datapath.
- Captures the 1024-bit squeezed string once the XOF reports done, then applies the centered binomial distribution (CBD, eta=2).
- Streams 256 coefficients, reduced mod q, over a valid/ready interface to the polynomial buffer / NTT input.

Parameters:
- Q, 3329, Kyber modulus used to map negative samples.
- N, 256, number of coefficients per polynomial.
- IN_W, 1024, width of PRF input (64*eta*8 bits, eta=2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request sampling of one polynomial; single-cycle pulse or level
- prf_in  input  IN_W  SHAKE256 output_string; byte j = prf_in[8j+7:8j], bit i of the stream = prf_in[i]
- prf_valid  input  1  SHAKE256 done flag; prf_in stable while high
- coeff_out  output  12  current coefficient in [0, Q-1]
- coeff_idx  output  8  index 0..255 of coeff_out
- coeff_valid  output  1  coeff_out/coeff_idx valid
- coeff_ready  input  1  downstream accepts when high with coeff_valid
- busy  output  1  high in ARM and EMIT
- done  output  1  high in DONE

Behaviour:
- Reset: every output is 0 (coeff_out, coeff_idx, coeff_valid, busy, done). The internal 1024-bit buffer is cleared. State is IDLE.
- FSM states: IDLE, ARM, EMIT, DONE.
- IDLE:
  - start=1 and prf_valid=1: capture prf_in into the buffer, idx<=0, go to EMIT.
  - start=1 and prf_valid=0: go to ARM.
- ARM: wait; on prf_valid=1, capture prf_in, idx<=0, go to EMIT. start is ignored here.
- EMIT:
  - coeff_valid=1. Outputs are registered; first coefficient appears the cycle after capture, giving 1-cycle latency.
  - Coefficient k uses buffer bits 4k..4k+3 (b0..b3): a=b0+b1, b=b2+b3, d=a-b in {-2..2}.
  - coeff_out = d if d>=0, else Q+d (3327 or 3328).
  - Handshake: transfer when coeff_valid && coeff_ready. On transfer, present coefficient k+1 the next cycle, giving 1 coefficient/cycle at full throughput.
  - If coeff_ready=0, coeff_out/coeff_idx hold unchanged and coeff_valid stays 1. Valid never drops without a transfer.
  - Transfer of idx 255: coeff_valid<=0, go to DONE. idx does not wrap and is not exposed past 255.
- DONE: done=1, held until next start. start in DONE behaves as start in IDLE (direct capture or ARM) and clears done the same cycle the state leaves DONE.
- start during ARM/EMIT is ignored. Sampling is not restarted and the buffer is not overwritten.
- prf_in/prf_valid changes after capture have no effect on the current polynomial.
- rst asserted mid-EMIT: immediate return to IDLE with all outputs 0. No partial-polynomial state survives.
- Width rules: a, b are 2-bit unsigned; d is 3-bit signed. Mapping is a single compare/add with no modular loop.

Test Plan:
- prf_in all zeros, start with prf_valid=1, coeff_ready=1 -> 256 transfers on 256 consecutive cycles starting 1 cycle after start, all coeff_out=0, idx 0..255; then done=1.
- prf_in byte0=0x31, byte1=0xC0, rest 0 -> coeff0=1, coeff1=2, coeff2=0, coeff3=3327, coeff4..255=0.
- prf_in all 0xFF -> all coeffs 0 (a=b=2); nibble 0x4 at coeff0 -> 3328.
- start with prf_valid=0, raise prf_valid 5 cycles later -> busy during wait, coeff_valid rises 1 cycle after prf_valid, coeff0 correct.
- coeff_ready toggled pseudo-randomly -> exactly 256 transfers, in order, no duplicates or drops, outputs stable while stalled; extra start pulse mid-EMIT is ignored.
- rst at idx 100 -> next cycle all outputs 0, state IDLE; new start produces a complete fresh 0..255 sequence.
